// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Pipelined adder/subtractor/comparator. The WIDTH-bit ripple-carry chain is
//   cut into SEG registered segments, so one operation completes in SEG cycles
//   at a rate of one result per cycle. Valid/ready handshake on both sides.
//
//   Operations (op): 00 ADD, 01 SUB, 11 SLT (signed), 10 SLTU (unsigned).
//   Flags (zero, overflow, cout) always describe the adder sum, whatever the op.
//
//   Optional feature: define ADDSUB_STICKY_OVF_EN to build the sticky overflow
//   flag. When undefined, sticky_ovf is tied low and ovf_clear is ignored.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle (combinational from output side)
//   a, b       in   WIDTH-bit operands
//   op         in   operation select
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts the result
//   result     out  sum/difference or zero-extended compare bit
//   zero       out  adder sum is all zero
//   overflow   out  signed overflow of the adder
//   cout       out  carry out of the adder MSB
//   ovf_clear  in   clears sticky_ovf
//   sticky_ovf out  sticky ADD/SUB overflow flag
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout,
  input  logic             ovf_clear,
  output logic             sticky_ovf
);

  localparam int SW = WIDTH / SEG;

  function automatic logic [SW:0] seg_add(input logic [SW-1:0] x,
                                          input logic [SW-1:0] y,
                                          input logic          cin);
    return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, cin};
  endfunction

  function automatic logic slt_bit(input logic sum_msb,
                                   input logic ovf,
                                   input logic a_msb);
    return (sum_msb & ~ovf) | (a_msb & ovf);
  endfunction

  // The whole pipeline moves together; it only stalls when the output
  // register holds a beat the consumer is not taking.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // *_p[k] is what segment k works on: index 0 comes straight from the
  // inputs, index k>0 from the register after segment k-1.
  logic [WIDTH-1:0] a_p   [SEG];
  logic [WIDTH-1:0] bx_p  [SEG];
  logic [WIDTH-1:0] sum_p [SEG];
  logic             c_p   [SEG];
  logic             vld_p [SEG];
  logic [1:0]       op_p  [SEG];

  logic invert;
  assign invert = op[0] | op[1];

  assign a_p[0]   = a;
  assign bx_p[0]  = invert ? ~b : b;
  assign sum_p[0] = '0;
  assign c_p[0]   = invert;
  assign vld_p[0] = in_valid;
  assign op_p[0]  = op;

  genvar k;
  generate
    for (k = 0; k < SEG - 1; k++) begin : g_stage
      logic [SW:0]      seg;
      logic [WIDTH-1:0] sum_nxt;
      logic [WIDTH-1:0] a_q, bx_q, sum_q;
      logic             c_q, vld_q;
      logic [1:0]       op_q;

      always_comb begin
        seg                  = seg_add(a_p[k][k*SW +: SW], bx_p[k][k*SW +: SW], c_p[k]);
        sum_nxt              = sum_p[k];
        sum_nxt[k*SW +: SW]  = seg[SW-1:0];
      end

      // ---- stage k register boundary ----
      always_ff @(posedge clk or posedge reset) begin
        if (reset)    vld_q <= 1'b0;
        else if (adv) vld_q <= vld_p[k];
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= a_p[k];
          bx_q  <= bx_p[k];
          sum_q <= sum_nxt;
          c_q   <= seg[SW];
          op_q  <= op_p[k];
        end
      end

      assign a_p[k+1]   = a_q;
      assign bx_p[k+1]  = bx_q;
      assign sum_p[k+1] = sum_q;
      assign c_p[k+1]   = c_q;
      assign vld_p[k+1] = vld_q;
      assign op_p[k+1]  = op_q;
    end
  endgenerate

  // Last segment: finish the sum and derive result and flags.
  logic [SW:0]      seg_f;
  logic [WIDTH-1:0] sum_f;
  logic [WIDTH-1:0] res_f;
  logic             a_msb, cin_msb, ovf_f;

  always_comb begin
    seg_f                       = seg_add(a_p[SEG-1][(SEG-1)*SW +: SW],
                                          bx_p[SEG-1][(SEG-1)*SW +: SW], c_p[SEG-1]);
    sum_f                       = sum_p[SEG-1];
    sum_f[(SEG-1)*SW +: SW]     = seg_f[SW-1:0];
    a_msb                       = a_p[SEG-1][WIDTH-1];
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    cin_msb                     = a_msb ^ bx_p[SEG-1][WIDTH-1] ^ sum_f[WIDTH-1];
    ovf_f                       = cin_msb ^ seg_f[SW];
    res_f                       = '0;
    case (op_p[SEG-1])
      2'b11:   res_f[0] = slt_bit(sum_f[WIDTH-1], ovf_f, a_msb);
      2'b10:   res_f[0] = ~seg_f[SW];
      default: res_f    = sum_f;
    endcase
  end

  // ---- output register boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      cout      <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_p[SEG-1];
      if (vld_p[SEG-1]) begin
        result   <= res_f;
        zero     <= ~|sum_f;
        overflow <= ovf_f;
        cout     <= seg_f[SW];
      end
    end
  end

`ifdef ADDSUB_STICKY_OVF_EN
  logic addsub_q;

  // Set has priority over clear when both happen at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addsub_q   <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      if (adv && vld_p[SEG-1]) addsub_q <= ~op_p[SEG-1][1];
      if (out_valid && out_ready && addsub_q && overflow) sticky_ovf <= 1'b1;
      else if (ovf_clear)                                 sticky_ovf <= 1'b0;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = ovf_clear;
  assign sticky_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int WIDTH = 32;
  localparam int SEG   = 4;
`ifdef ADDSUB_STICKY_OVF_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b11;
  localparam logic [1:0] OP_SLTU = 2'b10;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero, overflow, cout;
  logic             ovf_clear;
  logic             sticky_ovf;

  pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .cout       (cout),
    .ovf_clear  (ovf_clear),
    .sticky_ovf (sticky_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one beat with out_ready high and stop at the cycle where the result
  // is presented (not yet consumed). lat counts edges after the accept edge.
  task automatic run_beat(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    tick();
    in_valid  = 1'b0;
    lat       = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int sent, got, stall_cnt, stale;

    vecs[0] = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{OP_SLT,  32'h00000003, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{OP_SLTU, 32'h00000003, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{OP_ADD,  32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clear = 1'b0;
    a         = '0;
    b         = '0;
    op        = OP_ADD;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_sticky", {31'b0, sticky_ovf}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors, one beat each
    for (int i = 0; i < 10; i++) begin
      run_beat(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, SEG - 1);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].z});
      check($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].v});
      check($sformatf("v%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].c});
      tick();
    end

    // Back-to-back stream with a 3-cycle consumer stall
    sent      = 0;
    got       = 0;
    stall_cnt = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = (sent < 8);
      a         = sent;
      b         = sent;
      op        = OP_ADD;
      #1;
      check("stream_in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
      if (!in_ready) stall_cnt++;
      if (out_valid) check("stream_result", result, 2 * got);
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got, 8);
    check("stream_stall_cycles", stall_cnt, 3);
    #1;
    check("stream_no_extra", {31'b0, out_valid}, 32'd0);

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 100 + i;
      b        = 1;
      op       = OP_ADD;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("in_reset_valid", {31'b0, out_valid}, 32'd0);
    check("in_reset_result", result, 32'd0);
    tick();
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) stale++;
      tick();
    end
    check("post_reset_stale", stale, 0);
    run_beat(OP_ADD, 32'd10, 32'd20, lat);
    check("post_reset_latency", lat, SEG - 1);
    check("post_reset_result", result, 32'd30);
    tick();

    // Sticky overflow
    check("sticky_after_reset", {31'b0, sticky_ovf}, 32'd0);
    run_beat(OP_SLT, 32'h80000000, 32'h00000001, lat);
    tick();
    check("sticky_slt_ignored", {31'b0, sticky_ovf}, 32'd0);
    run_beat(OP_ADD, 32'h7FFFFFFF, 32'h00000001, lat);
    tick();
    check("sticky_set", {31'b0, sticky_ovf}, {31'b0, STK});
    run_beat(OP_ADD, 32'h7FFFFFFF, 32'h00000001, lat);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("sticky_set_wins", {31'b0, sticky_ovf}, {31'b0, STK});
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("sticky_clear", {31'b0, sticky_ovf}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
